regfile_store: RTL and testbench

- 32-entry x WIDTH-bit register storage with one write port and two read ports.
- Sits directly upstream of the per-bit 32:1 read-select muxes (mux32_1, one instance per bit per read port). It holds the architectural registers and presents the bit-transposed vectors those muxes consume.
- Read results are captured in output registers, giving a 1-cycle read latency for the pipelined datapath.
- Register ZERO_REG is hardwired to zero.

---
 rtl/regfile_store.sv | 89 ++++++++
 tb/tb_regfile_store.sv | 131 +++++++++++++
 2 files changed

// File: rtl/regfile_store.sv
// 32 x WIDTH register storage, one write port, two registered read ports.
// Optional RF_WR_BYPASS_EN: same-edge write-through to a read port naming the written index.

module mux32_1 (
  input  logic [31:0] din,
  input  logic [4:0]  sel,
  output logic        dout
);
  assign dout = din[sel];
endmodule

module regfile_store #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);
  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [31:0][WIDTH-1:0] regs_q, regs_d;
  logic [WIDTH-1:0][31:0] slice;
  logic [WIDTH-1:0]       sel_a, sel_b;
  logic [WIDTH-1:0]       rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]       rd_data_b_q, rd_data_b_d;
  logic                   wr_hit, byp_a, byp_b;

  assign wr_hit = wr_en && (wr_addr != ZR);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[wr_addr] = wr_data;
    regs_d[ZR] = '0;
  end

  // Bit-transposed view feeding the per-bit muxes; the zero slot is tied low.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    for (genvar r = 0; r < 32; r++) begin : g_reg
      if (r == ZERO_REG) begin : g_zero
        assign slice[i][r] = 1'b0;
      end else begin : g_data
        assign slice[i][r] = regs_q[r][i];
      end
    end
  end

  mux32_1 u_mux_a [WIDTH-1:0] (.din(slice), .sel(rd_addr_a), .dout(sel_a));
  mux32_1 u_mux_b [WIDTH-1:0] (.din(slice), .sel(rd_addr_b), .dout(sel_b));

`ifdef RF_WR_BYPASS_EN
  assign byp_a = wr_hit && (wr_addr == rd_addr_a);
  assign byp_b = wr_hit && (wr_addr == rd_addr_b);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_en) begin
      rd_data_a_d = byp_a ? wr_data : sel_a;
      rd_data_b_d = byp_b ? wr_data : sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
endmodule

// File: tb/tb_regfile_store.sv
// Directed self-checking bench for regfile_store (both RF_WR_BYPASS_EN builds).
module tb_regfile_store;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [63:0] wr_data, rd_data_a, rd_data_b;
  int checks = 0;
  int failures = 0;

  regfile_store #(.WIDTH(64), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  localparam logic [63:0] PAT  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

  initial begin
    logic [63:0] exp_a, exp_b;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    #12;
    chk("reset_a", rd_data_a, 64'h0);
    chk("reset_b", rd_data_b, 64'h0);
    step(); rst_n = 1'b1;

    // write 5, read it back, then async reset mid-cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF;
    step();
    idle(); rd_en = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    step();
    chk("pre_rst_a", rd_data_a, 64'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", rd_data_a, 64'h0);
    chk("async_rst_b", rd_data_b, 64'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_a", rd_data_a, 64'h0);
    chk("post_rst_b", rd_data_b, 64'h0);

    // basic write/read
    idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = PAT;
    step();
    idle(); rd_en = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd4;
    step();
    chk("basic_a", rd_data_a, PAT);
    chk("basic_b", rd_data_b, 64'h0);

    // zero register: discarded write, and no bypass for it
    idle(); wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
    step();
    rd_en = 1'b1; rd_addr_a = 5'd31; rd_addr_b = 5'd31;
    step();
    chk("zero_a", rd_data_a, 64'h0);
    chk("zero_b", rd_data_b, 64'h0);

    // hold with rd_en=0 while reg3 is overwritten
    idle(); rd_en = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
    step();
    idle(); rd_addr_a = 5'd7; rd_addr_b = 5'd31; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1;
    step();
    chk("hold_a", rd_data_a, PAT);
    chk("hold_b", rd_data_b, PAT);
    idle(); rd_en = 1'b1; rd_addr_a = 5'd3;
    step();
    chk("reg3_new", rd_data_a, 64'h1);

    // wr_en=0 must not write
    idle(); wr_addr = 5'd3; wr_data = 64'hBAD;
    step();
    rd_en = 1'b1; rd_addr_a = 5'd3;
    step();
    chk("no_wr_en", rd_data_a, 64'h1);

    // same-edge collision; port B reads 3 while 10 is written
    idle(); wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'h1111;
    step();
    wr_data = 64'h2222; rd_en = 1'b1; rd_addr_a = 5'd10; rd_addr_b = 5'd3;
    step();
`ifdef RF_WR_BYPASS_EN
    chk("collide_a", rd_data_a, 64'h2222);
`else
    chk("collide_a", rd_data_a, 64'h1111);
`endif
    chk("collide_b", rd_data_b, 64'h1);
    idle(); rd_en = 1'b1; rd_addr_a = 5'd10; rd_addr_b = 5'd10;
    step();
    chk("after_collide_a", rd_data_a, 64'h2222);
    chk("after_collide_b", rd_data_b, 64'h2222);

    // sweep
    for (int r = 0; r < 31; r++) begin
      idle(); wr_en = 1'b1; wr_addr = 5'(r); wr_data = 64'(r) * STEP;
      step();
    end
    for (int r = 0; r < 32; r++) begin
      idle(); rd_en = 1'b1; rd_addr_a = 5'(r); rd_addr_b = 5'(31 - r);
      step();
      exp_a = (r == 31) ? 64'h0 : 64'(r) * STEP;
      exp_b = (r == 0) ? 64'h0 : 64'(31 - r) * STEP;
      chk($sformatf("sweep_a[%0d]", r), rd_data_a, exp_a);
      chk($sformatf("sweep_b[%0d]", 31 - r), rd_data_b, exp_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
